// File: rtl/tx_seq_pkg_1553.sv
// Shared types, entry field layout and helpers for the 1553 transmit word sequencer.
package tx_seq_pkg_1553;

    localparam int WORD_W    = 18;
    localparam int CSW_BIT   = 17;
    localparam int DW_BIT    = 16;
    localparam int DWORD_MSB = 15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } seq_state_t;

    // An entry can be launched only when exactly one sync type is selected.
    function automatic logic entry_valid(input logic [WORD_W-1:0] entry);
        return entry[CSW_BIT] ^ entry[DW_BIT];
    endfunction

endpackage

// File: rtl/sync_fifo_1553.sv
// Show-ahead synchronous FIFO holding queued 1553 word entries.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module sync_fifo_1553
    import tx_seq_pkg_1553::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign overflow = push && full;
    assign head     = mem[rd_ptr[AW-1:0]];

    // Advance the pointers; a push while full is rejected even if a pop happens in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tx_word_sequencer_1553.sv
// Feeds queued 1553 words to the encoder one strobe at a time, waits for the
// encoder's busy handshake, and inserts the intermessage gap before a new
// command/status word that follows a completed word.
module tx_word_sequencer_1553
    import tx_seq_pkg_1553::*;
#(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int GAP_CYCLES = 8,
    parameter int BUSY_TO    = 4
) (
    input  logic              enc_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic [15:0]       tx_dword,
    output logic              tx_csw,
    output logic              tx_dw,
    input  logic              tx_busy,
    output logic              seq_busy,
    output logic              err
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TO - 1);

    seq_state_t         state;
    logic [WORD_W-1:0]  head;
    logic               head_csw;
    logic               head_dw;
    logic               pop;
    logic               overflow;
    logic               invalid_drop;
    logic               busy_timeout;
    logic               gap_pending;
    logic               busy_q;
    logic [CNT_W-1:0]   gap_cnt;
    logic [CNT_W-1:0]   busy_cnt;
    logic [15:0]        held_dword;

    sync_fifo_1553 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (enc_clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    assign head_csw     = head[CSW_BIT];
    assign head_dw      = head[DW_BIT];
    assign pop          = (state == IDLE) && enable && !empty && !tx_busy;
    assign invalid_drop = pop && !entry_valid(head);
    assign busy_timeout = (state == WAIT_BUSY) && !tx_busy && (busy_cnt == BUSY_LAST);
    assign seq_busy     = (state != IDLE);

    // Previous tx_busy sample, used to see the encoder finishing a word.
    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= tx_busy;
        end
    end

    // Sequencer FSM with registered strobe, word and error outputs.
    always_ff @(posedge enc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gap_pending <= 1'b0;
            gap_cnt     <= '0;
            busy_cnt    <= '0;
            held_dword  <= '0;
            tx_dword    <= '0;
            tx_csw      <= 1'b0;
            tx_dw       <= 1'b0;
            err         <= 1'b0;
        end else begin
            tx_dword <= '0;
            tx_csw   <= 1'b0;
            tx_dw    <= 1'b0;
            err      <= overflow | invalid_drop | busy_timeout;

            case (state)
                IDLE: begin
                    if (pop && entry_valid(head)) begin
                        held_dword <= head[DWORD_MSB:0];
                        if (head_csw && gap_pending) begin
                            state       <= GAP;
                            gap_cnt     <= '0;
                            gap_pending <= 1'b0;
                        end else begin
                            state    <= LOAD;
                            busy_cnt <= '0;
                            tx_dword <= head[DWORD_MSB:0];
                            tx_csw   <= head_csw;
                            tx_dw    <= head_dw;
                            if (head_dw) begin
                                gap_pending <= 1'b0;
                            end
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= LOAD;
                        busy_cnt <= '0;
                        tx_dword <= held_dword;
                        tx_csw   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                LOAD: begin
                    state    <= WAIT_BUSY;
                    busy_cnt <= busy_cnt + 1'b1;
                end

                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (busy_cnt == BUSY_LAST) begin
                        state <= IDLE;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (busy_q && !tx_busy) begin
                        state       <= IDLE;
                        gap_pending <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_word_sequencer_1553.sv
// Self-checking bench for tx_word_sequencer_1553: table-driven FIFO fill vectors
// plus directed sequences for gap timing, invalid entries, timeouts and reset.
module tb_tx_word_sequencer_1553;

    localparam int DEPTH      = 16;
    localparam int AW         = 4;
    localparam int GAP_CYCLES = 8;
    localparam int BUSY_TO    = 4;

    logic          enc_clk;
    logic          rst_n;
    logic          enable;
    logic          wr_en;
    logic [17:0]   wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic [15:0]   tx_dword;
    logic          tx_csw;
    logic          tx_dw;
    logic          tx_busy;
    logic          seq_busy;
    logic          err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic model_en = 1'b0;
    int   busy_len = 10;

    typedef struct {
        int          cyc;
        logic        csw;
        logic        dw;
        logic [15:0] dword;
    } strobe_t;

    typedef struct {
        int   cyc;
        logic seq_busy;
    } err_t;

    typedef struct {
        logic        enable;
        logic        wr_en;
        logic [17:0] wr_data;
        logic        exp_full;
        logic        exp_empty;
        logic [4:0]  exp_level;
        logic        exp_err;
    } vec_t;

    int      fall_q[$];
    strobe_t strobe_q[$];
    err_t    err_q[$];
    vec_t    vecs[19];

    tx_word_sequencer_1553 #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .GAP_CYCLES (GAP_CYCLES),
        .BUSY_TO    (BUSY_TO)
    ) dut (
        .enc_clk  (enc_clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .tx_dword (tx_dword),
        .tx_csw   (tx_csw),
        .tx_dw    (tx_dw),
        .tx_busy  (tx_busy),
        .seq_busy (seq_busy),
        .err      (err)
    );

    // 100 MHz-style free-running clock; only relative cycle counts matter.
    initial begin
        enc_clk = 1'b0;
        forever #5 enc_clk = ~enc_clk;
    end

    // Count rising edges so events can be timed in cycles.
    initial begin
        forever begin
            @(posedge enc_clk);
            cyc++;
        end
    end

    // Encoder model: raises tx_busy two cycles after a strobe, holds it busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge enc_clk);
            if (model_en && (tx_csw || tx_dw)) begin
                @(negedge enc_clk);
                @(negedge enc_clk);
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge enc_clk);
                tx_busy = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    end

    // Log every strobe and error pulse with the cycle it was seen in.
    initial begin
        forever begin
            @(negedge enc_clk);
            if (tx_csw || tx_dw) begin
                strobe_q.push_back('{cyc, tx_csw, tx_dw, tx_dword});
            end
            if (err) begin
                err_q.push_back('{cyc, seq_busy});
            end
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge enc_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic we, input logic [17:0] d);
        enable  = en;
        wr_en   = we;
        wr_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_dword"}, 32'(tx_dword), 32'h0);
        checkOutput({tag, "_tx_csw"},   32'(tx_csw),   32'h0);
        checkOutput({tag, "_tx_dw"},    32'(tx_dw),    32'h0);
        checkOutput({tag, "_err"},      32'(err),      32'h0);
        checkOutput({tag, "_seq_busy"}, 32'(seq_busy), 32'h0);
        checkOutput({tag, "_full"},     32'(full),     32'h0);
        checkOutput({tag, "_empty"},    32'(empty),    32'h1);
        checkOutput({tag, "_level"},    32'(level),    32'h0);
    endtask

    task automatic clearLogs();
        fall_q.delete();
        strobe_q.delete();
        err_q.delete();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 18'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clearLogs();
    endtask

    task automatic waitFalls(input int n, input int limit, input string name);
        int k;
        k = 0;
        while (fall_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        checkOutput(name, 32'(fall_q.size()), 32'(n));
    endtask

    initial begin
        int k;
        logic found;
        int s0;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b0, 1'b1, {2'b01, 16'(i)}, (i == 15), 1'b0, 5'(i + 1), 1'b0};
        end
        vecs[16] = '{1'b0, 1'b1, {2'b01, 16'hBEEF}, 1'b1, 1'b0, 5'd16, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 18'h0,             1'b1, 1'b0, 5'd16, 1'b0};
        vecs[18] = '{1'b1, 1'b1, {2'b01, 16'hCAFE}, 1'b0, 1'b0, 5'd15, 1'b1};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 18'h0);
        #2;
        checkResetValues("reset_async");
        doReset();
        checkResetValues("reset_idle");

        // Single CSW through the busy handshake.
        model_en = 1'b1;
        busy_len = 40;
        applyStimulus(1'b1, 1'b1, {2'b10, 16'h5555});
        tick();
        applyStimulus(1'b1, 1'b0, 18'h0);
        checkOutput("t1_level_after_push", 32'(level), 32'd1);
        found = 1'b0;
        k = 0;
        while (!found && k < 10) begin
            tick();
            k++;
            found = tx_csw || tx_dw;
        end
        checkOutput("t1_strobe_seen", 32'(found), 32'd1);
        checkOutput("t1_latency", 32'(k), 32'd1);
        checkOutput("t1_tx_csw", 32'(tx_csw), 32'd1);
        checkOutput("t1_tx_dw", 32'(tx_dw), 32'd0);
        checkOutput("t1_tx_dword", 32'(tx_dword), 32'h5555);
        checkOutput("t1_level_after_pop", 32'(level), 32'd0);
        tick();
        checkOutput("t1_csw_one_cycle", 32'(tx_csw), 32'd0);
        checkOutput("t1_dword_cleared", 32'(tx_dword), 32'h0);
        waitFalls(1, 100, "t1_busy_fall");
        checkOutput("t1_seq_busy_at_fall", 32'(seq_busy), 32'd1);
        tick();
        checkOutput("t1_seq_busy_after_fall", 32'(seq_busy), 32'd0);
        checkOutput("t1_no_err", 32'(err_q.size()), 32'd0);

        // Message CSW, DW, DW then a new CSW that must wait out the gap.
        doReset();
        model_en = 1'b1;
        busy_len = 12;
        applyStimulus(1'b1, 1'b1, {2'b10, 16'hABCD});
        tick();
        applyStimulus(1'b1, 1'b1, {2'b01, 16'h1234});
        tick();
        applyStimulus(1'b1, 1'b1, {2'b01, 16'h5678});
        tick();
        applyStimulus(1'b1, 1'b1, {2'b10, 16'hAAAA});
        tick();
        applyStimulus(1'b1, 1'b0, 18'h0);
        waitFalls(4, 400, "t2_all_done");
        checkOutput("t2_strobe_count", 32'(strobe_q.size()), 32'd4);
        checkOutput("t2_no_err", 32'(err_q.size()), 32'd0);
        if (strobe_q.size() == 4 && fall_q.size() >= 3) begin
            checkOutput("t2_w0", {14'h0, strobe_q[0].csw, strobe_q[0].dw, strobe_q[0].dword}, {14'h0, 2'b10, 16'hABCD});
            checkOutput("t2_w1", {14'h0, strobe_q[1].csw, strobe_q[1].dw, strobe_q[1].dword}, {14'h0, 2'b01, 16'h1234});
            checkOutput("t2_w2", {14'h0, strobe_q[2].csw, strobe_q[2].dw, strobe_q[2].dword}, {14'h0, 2'b01, 16'h5678});
            checkOutput("t2_w3", {14'h0, strobe_q[3].csw, strobe_q[3].dw, strobe_q[3].dword}, {14'h0, 2'b10, 16'hAAAA});
            checkOutput("t2_dw1_delay", 32'(strobe_q[1].cyc - fall_q[0]), 32'd2);
            checkOutput("t2_dw2_delay", 32'(strobe_q[2].cyc - fall_q[1]), 32'd2);
            checkOutput("t2_csw_gap_delay", 32'(strobe_q[3].cyc - fall_q[2]), 32'(GAP_CYCLES + 2));
        end

        // FIFO fill with launches disabled, overflow, and push+pop while full.
        doReset();
        model_en = 1'b0;
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].enable, vecs[i].wr_en, vecs[i].wr_data);
            tick();
            checkOutput($sformatf("t3_row%0d_full", i),  32'(full),  32'(vecs[i].exp_full));
            checkOutput($sformatf("t3_row%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            checkOutput($sformatf("t3_row%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
            checkOutput($sformatf("t3_row%0d_err", i),   32'(err),   32'(vecs[i].exp_err));
        end
        applyStimulus(1'b0, 1'b0, 18'h0);

        // Invalid entry is dropped with an error, the following DW still launches.
        doReset();
        model_en = 1'b1;
        busy_len = 6;
        applyStimulus(1'b1, 1'b1, {2'b11, 16'hFFFF});
        tick();
        applyStimulus(1'b1, 1'b1, {2'b01, 16'h0001});
        tick();
        applyStimulus(1'b1, 1'b0, 18'h0);
        waitFalls(1, 100, "t4_busy_fall");
        checkOutput("t4_err_count", 32'(err_q.size()), 32'd1);
        checkOutput("t4_strobe_count", 32'(strobe_q.size()), 32'd1);
        if (strobe_q.size() == 1) begin
            checkOutput("t4_word", {14'h0, strobe_q[0].csw, strobe_q[0].dw, strobe_q[0].dword}, {14'h0, 2'b01, 16'h0001});
        end

        // Encoder never answers: timeout error, word lost, next entry launches.
        doReset();
        model_en = 1'b0;
        applyStimulus(1'b1, 1'b1, {2'b01, 16'h0AAA});
        tick();
        applyStimulus(1'b1, 1'b1, {2'b10, 16'h0BBB});
        tick();
        applyStimulus(1'b1, 1'b0, 18'h0);
        repeat (20) tick();
        checkOutput("t5_strobe_count", 32'(strobe_q.size()), 32'd2);
        checkOutput("t5_err_count", 32'(err_q.size()), 32'd2);
        if (strobe_q.size() == 2 && err_q.size() == 2) begin
            s0 = strobe_q[0].cyc;
            checkOutput("t5_w0", {14'h0, strobe_q[0].csw, strobe_q[0].dw, strobe_q[0].dword}, {14'h0, 2'b01, 16'h0AAA});
            checkOutput("t5_w1", {14'h0, strobe_q[1].csw, strobe_q[1].dw, strobe_q[1].dword}, {14'h0, 2'b10, 16'h0BBB});
            checkOutput("t5_err0_cycle", 32'(err_q[0].cyc - s0), 32'(BUSY_TO));
            checkOutput("t5_idle_at_err", 32'(err_q[0].seq_busy), 32'd0);
            checkOutput("t5_next_launch", 32'(strobe_q[1].cyc - s0), 32'(BUSY_TO + 1));
            checkOutput("t5_err1_cycle", 32'(err_q[1].cyc - strobe_q[1].cyc), 32'(BUSY_TO));
        end

        // Asynchronous reset while waiting for the encoder with entries queued.
        doReset();
        model_en = 1'b1;
        busy_len = 30;
        applyStimulus(1'b1, 1'b1, {2'b10, 16'h1111});
        tick();
        applyStimulus(1'b1, 1'b1, {2'b01, 16'h2222});
        tick();
        applyStimulus(1'b1, 1'b1, {2'b01, 16'h3333});
        tick();
        applyStimulus(1'b1, 1'b1, {2'b01, 16'h4444});
        tick();
        applyStimulus(1'b1, 1'b0, 18'h0);
        k = 0;
        while (!tx_busy && k < 20) begin
            tick();
            k++;
        end
        checkOutput("t6_busy_seen", 32'(tx_busy), 32'd1);
        tick();
        tick();
        checkOutput("t6_seq_busy_pre", 32'(seq_busy), 32'd1);
        checkOutput("t6_level_pre", 32'(level), 32'd3);
        rst_n = 1'b0;
        #1;
        checkResetValues("t6_async");
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("t6_empty_post", 32'(empty), 32'd1);
        checkOutput("t6_level_post", 32'(level), 32'd0);
        checkOutput("t6_seq_busy_post", 32'(seq_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
